// File: rtl/gate_chk_pkg.sv
// ---------------------------------------------------------------------------
// gate_chk_pkg
// Shared definitions for the 2-input gate truth-table checker:
//   - state_e : FSM state encoding (idle, apply vectors, done pulse)
//   - *_TT    : expected truth tables, bit index = {a, b}
//   - tt_bit  : helper returning the expected gate output for one vector
// ---------------------------------------------------------------------------
package gate_chk_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StApply = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Truth tables indexed by {a, b}: bit 0 = (0,0) ... bit 3 = (1,1).
    localparam logic [3:0] AND_TT  = 4'b1000;
    localparam logic [3:0] OR_TT   = 4'b1110;
    localparam logic [3:0] XOR_TT  = 4'b0110;
    localparam logic [3:0] NAND_TT = 4'b0111;

    // Number of vectors in one run; the idx counter is sized for exactly this.
    localparam int unsigned NUM_VEC = 4;

    function automatic logic tt_bit(input logic [3:0] tt, input logic [1:0] idx);
        return tt[idx];
    endfunction

endpackage

// File: rtl/gate_tt_checker.sv
// ---------------------------------------------------------------------------
// gate_tt_checker
// Drives the four input combinations {a,b} = 00, 01, 10, 11 into an external
// 2-input gate, waits SETTLE extra cycles per vector, samples the gate output
// and compares it against the expected truth table EXP_TT.
//
// Parameters:
//   SETTLE  - extra wait cycles per vector before sampling (0..15)
//   EXP_TT  - expected truth table, bit index = {a_out, b_out}
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request one 4-vector run (accepted only in idle)
//   dut_c     in   output of the gate under test
//   a_out     out  gate input a
//   b_out     out  gate input b
//   busy      out  high while a run is in progress (apply and done states)
//   done      out  one-cycle pulse at the end of a run
//   pass      out  last completed run had zero mismatches
//   err_count out  mismatch count of the last or current run (0..4)
//   fail_vec  out  bit i set when vector i mismatched
// ---------------------------------------------------------------------------
module gate_tt_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned SETTLE = 2,
    parameter logic [3:0]  EXP_TT = AND_TT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_c,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);
    localparam logic [1:0] LAST_IDX  = 2'(NUM_VEC - 1);

    state_e     r_state;
    logic [1:0] r_idx;
    logic [3:0] r_cnt;
    logic       r_a;
    logic       r_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_err;
    logic [3:0] r_fail;

    logic       w_mismatch;
    logic [2:0] w_err_next;
    logic [1:0] w_idx_next;

    // Compare at the sample edge against the vector currently on the pins.
    assign w_mismatch = (dut_c != tt_bit(EXP_TT, r_idx));
    // At most four samples per run, so a 3-bit count never wraps.
    assign w_err_next = r_err + {2'b00, w_mismatch};
    assign w_idx_next = r_idx + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_idx   <= 2'd0;
            r_cnt   <= 4'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 3'd0;
            r_fail  <= 4'd0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state <= StApply;
                        r_idx   <= 2'd0;
                        r_cnt   <= SETTLE_LD;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_busy  <= 1'b1;
                        r_pass  <= 1'b0;
                        r_err   <= 3'd0;
                        r_fail  <= 4'd0;
                    end
                end

                StApply: begin
                    if (r_cnt != 4'd0) begin
                        // Settling: pins and idx hold.
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_err <= w_err_next;
                        if (w_mismatch) begin
                            r_fail[r_idx] <= 1'b1;
                        end
                        if (r_idx == LAST_IDX) begin
                            r_state <= StDone;
                            r_a     <= 1'b0;
                            r_b     <= 1'b0;
                            r_done  <= 1'b1;
                            // Uses the count including this final sample.
                            r_pass  <= (w_err_next == 3'd0);
                        end else begin
                            r_idx <= w_idx_next;
                            r_a   <= w_idx_next[1];
                            r_b   <= w_idx_next[0];
                            r_cnt <= SETTLE_LD;
                        end
                    end
                end

                StDone: begin
                    // Unconditional return; a held start is only seen again in idle.
                    r_state <= StIdle;
                    r_idx   <= 2'd0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_tt_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_tt_checker
// Three checker instances share clock and reset:
//   u0: SETTLE=2, EXP_TT=AND_TT, driving a real AND gate (all vectors match)
//   u1: SETTLE=2, EXP_TT=OR_TT,  driving a real AND gate (vectors 1,2 differ)
//   u2: SETTLE=0, EXP_TT=AND_TT, dut_c tied high        (vectors 0,1,2 differ)
// Cycle numbering: cycle 1 is the cycle that begins at the accepted start edge.
// ---------------------------------------------------------------------------
module tb_gate_tt_checker;
    import gate_chk_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start0, start1, start2;
    logic       a0, b0, busy0, done0, pass0;
    logic       a1, b1, busy1, done1, pass1;
    logic       a2, b2, busy2, done2, pass2;
    logic [2:0] err0, err1, err2;
    logic [3:0] fail0, fail1, fail2;
    logic       c0, c1;

    assign c0 = a0 & b0;
    assign c1 = a1 & b1;

    gate_tt_checker #(.SETTLE(2), .EXP_TT(AND_TT)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_c(c0),
        .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fail0)
    );

    gate_tt_checker #(.SETTLE(2), .EXP_TT(OR_TT)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_c(c1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fail1)
    );

    gate_tt_checker #(.SETTLE(0), .EXP_TT(AND_TT)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dut_c(1'b1),
        .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_vec(fail2)
    );

    int n_asserts = 0;
    int n_fail    = 0;
    int dones0, dones1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] ab_exp;

        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_ab0",   {a0, b0}, 2'b00);
        check("rst_busy0", busy0, 1'b0);
        check("rst_done0", done0, 1'b0);
        check("rst_pass0", pass0, 1'b0);
        check("rst_err0",  err0, 3'd0);
        check("rst_fail0", fail0, 4'd0);
        rst_n = 1'b1;
        tick();

        // AND gate vs AND_TT (u0) and vs OR_TT (u1), SETTLE=2
        start0 = 1'b1;
        start1 = 1'b1;
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            ab_exp = (c <= 12) ? 2'((c - 1) / 3) : 2'b00;
            check("seq_ab0",   {a0, b0}, ab_exp);
            check("seq_done0", done0, (c == 13));
            check("seq_busy0", busy0, 1'b1);
            check("seq_done1", done1, (c == 13));
            if (c < 13) tick();
        end
        tick();
        check("r1_busy0", busy0, 1'b0);
        check("r1_done0", done0, 1'b0);
        check("r1_pass0", pass0, 1'b1);
        check("r1_err0",  err0, 3'd0);
        check("r1_fail0", fail0, 4'b0000);
        check("r1_pass1", pass1, 1'b0);
        check("r1_err1",  err1, 3'd2);
        check("r1_fail1", fail1, 4'b0110);

        // Results hold in idle
        repeat (3) tick();
        check("hold_pass0", pass0, 1'b1);
        check("hold_err1",  err1, 3'd2);
        check("hold_fail1", fail1, 4'b0110);
        check("hold_ab0",   {a0, b0}, 2'b00);

        // SETTLE=0, dut_c stuck high
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            ab_exp = (c <= 4) ? 2'(c - 1) : 2'b00;
            check("s0_ab2",   {a2, b2}, ab_exp);
            check("s0_done2", done2, (c == 5));
            if (c < 5) tick();
        end
        tick();
        check("s0_err2",  err2, 3'd3);
        check("s0_fail2", fail2, 4'b0111);
        check("s0_pass2", pass2, 1'b0);
        check("s0_busy2", busy2, 1'b0);

        // start held high: one done per run, re-accept only from idle
        start0 = 1'b1;
        start1 = 1'b1;
        tick();
        check("held_clr_pass0", pass0, 1'b0);
        check("held_clr_err1",  err1, 3'd0);
        check("held_clr_fail1", fail1, 4'b0000);
        dones0 = 0;
        dones1 = 0;
        for (int c = 1; c <= 14; c++) begin
            if (done0) dones0++;
            if (done1) dones1++;
            if (c < 14) tick();
        end
        check("held_idle_busy0", busy0, 1'b0);
        check("held_dones0", dones0, 1);
        check("held_dones1", dones1, 1);
        check("held_res_err1", err1, 3'd2);
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        check("held_rerun_busy0", busy0, 1'b1);
        check("held_rerun_pass0", pass0, 1'b0);
        check("held_rerun_err1",  err1, 3'd0);
        check("held_rerun_fail1", fail1, 4'b0000);
        dones0 = 0;
        for (int k = 0; k < 13; k++) begin
            tick();
            if (done0) dones0++;
        end
        check("rerun_dones0", dones0, 1);
        check("rerun_busy0",  busy0, 1'b0);
        check("rerun_pass0",  pass0, 1'b1);
        check("rerun_err1",   err1, 3'd2);

        // Reset asserted during vector 2
        start0 = 1'b1;
        start1 = 1'b1;
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (7) tick();
        check("pre_rst_ab0",   {a0, b0}, 2'b10);
        check("pre_rst_err1",  err1, 3'd1);
        check("pre_rst_fail1", fail1, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ab0",   {a0, b0}, 2'b00);
        check("arst_busy0", busy0, 1'b0);
        check("arst_done0", done0, 1'b0);
        check("arst_ab1",   {a1, b1}, 2'b00);
        check("arst_busy1", busy1, 1'b0);
        check("arst_err1",  err1, 3'd0);
        check("arst_fail1", fail1, 4'b0000);
        check("arst_err2",  err2, 3'd0);
        check("arst_fail2", fail2, 4'b0000);
        repeat (2) tick();
        rst_n = 1'b1;
        dones0 = 0;
        dones1 = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done0) dones0++;
            if (done1) dones1++;
        end
        check("post_rst_dones0", dones0, 0);
        check("post_rst_dones1", dones1, 0);
        check("post_rst_busy0",  busy0, 1'b0);

        // Clean run after reset
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (13) tick();
        check("clean_pass0", pass0, 1'b1);
        check("clean_err0",  err0, 3'd0);
        check("clean_fail0", fail0, 4'b0000);
        check("clean_busy0", busy0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_tt_checker.md
GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning extra wait cycles per vector before sampling (legal range 0..15).
REQ-002 SHALL have parameter EXP_TT, default 4'b1000, meaning expected truth table; bit index = {a_out,b_out} (default = 2-input AND).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request one full 4-vector check run.
REQ-006 SHALL have port dut_c  input  1  output of the 2-input gate under test.
REQ-007 SHALL have port a_out  output  1  drives gate input a.
REQ-008 SHALL have port b_out  output  1  drives gate input b.
REQ-009 SHALL have port busy  output  1  high while a run is in progress.
REQ-010 SHALL have port done  output  1  single-cycle pulse at the end of a run.
REQ-011 SHALL have port pass  output  1  high when the last completed run had zero mismatches.
REQ-012 SHALL have port err_count  output  3  mismatch count of the last or current run (0..4).
REQ-013 SHALL have port fail_vec  output  4  bit i set when vector i mismatched.

Function
REQ-014 SHALL implement states IDLE, APPLY and DONE as a registered FSM.
REQ-015 In IDLE, start=1 at a rising edge SHALL move the FSM to APPLY, set idx=0, set {a_out,b_out}=2'b00, load settle counter with SETTLE, and clear err_count, fail_vec and pass.
REQ-016 In APPLY with counter>0, the counter SHALL decrement by 1 per cycle; a_out, b_out and idx SHALL hold.
REQ-017 In APPLY with counter==0, the block SHALL compare dut_c with EXP_TT[idx] at that edge; on mismatch it SHALL set fail_vec[idx] and increment err_count.
REQ-018 On the sample edge with idx<3, idx SHALL increment, {a_out,b_out} SHALL take the new idx, and the counter SHALL reload with SETTLE.
REQ-019 On the sample edge with idx==3, the FSM SHALL go to DONE and {a_out,b_out} SHALL return to 2'b00.
REQ-020 Each vector SHALL occupy exactly SETTLE+1 cycles, and done SHALL be high exactly 4*(SETTLE+1)+1 cycles after the start edge.
REQ-021 DONE SHALL last one cycle with done=1, set pass=(final err_count==0), and then go to IDLE unconditionally.
REQ-022 start SHALL be ignored in APPLY and in DONE; a new run requires start high while in IDLE.
REQ-023 busy SHALL be 1 exactly in APPLY and DONE.
REQ-024 pass, err_count and fail_vec SHALL hold their values in IDLE until the next accepted start.
REQ-025 When SETTLE=0, each vector SHALL be driven and sampled in one cycle.
REQ-026 err_count SHALL never exceed 4; the 3-bit width covers the full range with no wrap-around.

Reset
REQ-027 When rst_n is low, the block SHALL asynchronously force: FSM=IDLE, idx=0, counter=0, a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
REQ-028 Reset asserted mid-run SHALL abort the run with no done pulse; after rst_n deasserts, the block SHALL wait in IDLE for start.

Structure
REQ-029 Package gate_chk_pkg SHALL hold the state encoding and the truth-table constants AND_TT=4'b1000, OR_TT=4'b1110, XOR_TT=4'b0110 and NAND_TT=4'b0111.
REQ-030 The block SHALL be a single module with no sub-modules; the settle counter and the FSM are inline.

Verification
REQ-031 Bench SHALL check: andGate as DUT, SETTLE=2, start pulse -> a/b sequence 00,01,10,11 with 3 cycles each; done at cycle 13; pass=1; err_count=0; fail_vec=0000.
REQ-032 Bench SHALL check: andGate as DUT, EXP_TT=OR_TT -> vectors 01 and 10 mismatch; err_count=2; fail_vec=0110; pass=0.
REQ-033 Bench SHALL check: SETTLE=0 with dut_c tied to 1 and EXP_TT=AND_TT -> done at cycle 5; err_count=3; fail_vec=0111.
REQ-034 Bench SHALL check: start held high throughout a run -> exactly one done per run; a second run begins only from IDLE; results are cleared on the second accepted start.
REQ-035 Bench SHALL check: rst_n pulsed low during vector 2 -> all outputs are 0 immediately (before the next clk edge); no done pulse; a clean run after release gives pass=1.
